// File: rtl/fifo_ser_tx_pkg.sv
// Shared types and constants for the FIFO-draining serial transmitter.
// Optional parity stage is enabled by defining FIFO_SER_TX_PARITY_EN.
package fifo_ser_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef FIFO_SER_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   localparam logic TX_IDLE  = 1'b1;
   localparam logic TX_START = 1'b0;
   localparam logic TX_STOP  = 1'b1;

   localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/fifo_ser_tx_bit_timer.sv
// Bit-period timer: pulses bit_done on the last clk of each CLKS_PER_BIT window.
// Held at zero while clear is high so every bit starts from a fresh count.
module fifo_ser_tx_bit_timer
   import fifo_ser_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_done
);

   logic [15:0] r_cnt;
   logic        w_wrap;

   assign w_wrap   = (r_cnt == 16'(CLKS_PER_BIT - 1));
   assign bit_done = w_wrap && !clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/fifo_ser_tx.sv
// Pops bytes from a FIFO and sends them as start/data(LSB first)/stop frames.
// Define FIFO_SER_TX_PARITY_EN to insert an even-parity bit before stop.
module fifo_ser_tx
   import fifo_ser_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empt,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic [7:0]        frame_cnt
);

   localparam int BCW = $clog2(DATA_W + 1);

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shift_dn;
   logic [BCW-1:0]    r_bit_cnt;
   logic [7:0]        r_frame_cnt;
   logic              r_tx, w_tx_nxt;
   logic              w_bit_done, w_timer_clr, w_last_bit;
`ifdef FIFO_SER_TX_PARITY_EN
   logic              r_parity;
`endif

   assign w_timer_clr = (r_state == S_IDLE) || (r_state == S_POP) || (r_state == S_LOAD);
   assign w_last_bit  = (r_bit_cnt == BCW'(DATA_W - 1));
   assign w_shift_dn  = r_shift >> 1;

   fifo_ser_tx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_timer_clr),
      .bit_done (w_bit_done)
   );

   // tx is registered from the next-state decode so it only moves on bit boundaries
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      case (r_state)
         S_IDLE: begin
            if (tx_en && !fifo_empt) w_state_nxt = S_POP;
         end
         S_POP: begin
            w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_state_nxt = S_START;
            w_shift_nxt = fifo_data;
            w_tx_nxt    = TX_START;
         end
         S_START: begin
            if (w_bit_done) begin
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_done) begin
               w_shift_nxt = w_shift_dn;
               if (w_last_bit) begin
`ifdef FIFO_SER_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
                  w_tx_nxt    = r_parity;
`else
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = TX_STOP;
`endif
               end else begin
                  w_tx_nxt = w_shift_dn[0];
               end
            end
         end
`ifdef FIFO_SER_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_done) begin
               w_state_nxt = S_STOP;
               w_tx_nxt    = TX_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_bit_done) w_state_nxt = (tx_en && !fifo_empt) ? S_POP : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_frame_cnt <= '0;
         r_tx        <= TX_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         if (r_state == S_LOAD) begin
            r_bit_cnt <= '0;
         end else if (r_state == S_DATA && w_bit_done) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (r_state == S_STOP && w_bit_done) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

`ifdef FIFO_SER_TX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (r_state == S_LOAD) begin
         r_parity <= ^fifo_data;
      end
   end
`endif

   assign fifo_rd_en = (r_state == S_POP);
   assign busy       = (r_state != S_IDLE);
   assign tx         = r_tx;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Directed bench for fifo_ser_tx at CLKS_PER_BIT=4 with a small behavioural FIFO.
// Define FIFO_SER_TX_PARITY_EN to build and check the parity variant.
module tb_fifo_ser_tx;

   localparam int CPB = 4;
`ifdef FIFO_SER_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_en;
   logic       fifo_empt;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic [7:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mem [0:15];
   int  wp = 0;
   int  rp = 0;
   int  pops = 0;
   int  underflow = 0;
   int  dbl = 0;
   logic prev_rd = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   fifo_ser_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_W       (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empt  (fifo_empt),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   assign fifo_empt = (wp == rp);

   // Registered read port: data appears the cycle after the pop strobe
   always @(posedge clk) begin
      if (flush) begin
         rp <= wp;
      end else if (fifo_rd_en) begin
         pops <= pops + 1;
         if (wp == rp) begin
            underflow <= underflow + 1;
         end else begin
            fifo_data <= mem[rp[3:0]];
            rp        <= rp + 1;
         end
      end
      if (fifo_rd_en && prev_rd) dbl <= dbl + 1;
      prev_rd <= fifo_rd_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      mem[wp[3:0]] = v;
      wp = wp + 1;
   endtask

   function automatic logic [15:0] exp_frame(input logic [7:0] d);
      logic [15:0] f;
      f      = '0;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef FIFO_SER_TX_PARITY_EN
      f[9]   = ^d;
      f[10]  = 1'b1;
`else
      f[9]   = 1'b1;
`endif
      return f;
   endfunction

   task automatic wait_start(output int idle_seen, output int tmo);
      idle_seen = 0;
      tmo       = 1;
      for (int i = 0; i < 300; i++) begin
         if (tx == 1'b0) begin
            tmo = 0;
            break;
         end
         if (!busy) idle_seen++;
         @(negedge clk);
      end
      chk("start_timeout", 32'(tmo), 32'd0);
   endtask

   // Samples one frame at negedges starting on the first start-bit cycle
   task automatic rx_frame(input int drop_at, output logic [15:0] bits,
                           output int hold_err, output int idle_seen, output logic last_busy);
      int tmo;
      int idx;
      bits      = '0;
      hold_err  = 0;
      last_busy = 1'b0;
      wait_start(idle_seen, tmo);
      if (tmo == 0) begin
         idx = 0;
         for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
               if (idx == drop_at) tx_en = 1'b0;
               if (c == 0) bits[b] = tx;
               else if (tx !== bits[b]) hold_err++;
               last_busy = busy;
               idx++;
               @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      logic [15:0] fr;
      int          he;
      int          idl;
      int          p0;
      int          bad_rd;
      int          bad_tx;
      int          bad_busy;
      int          tmo;
      logic        lb;

      rst   = 1'b1;
      tx_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

      // Single frame 0xA5; no pop may happen while reset is still high
      push(8'hA5);
      tx_en = 1'b1;
      @(negedge clk);
      chk("rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
      p0  = pops;
      rst = 1'b0;
      @(negedge clk);
      chk("first_pop", 32'(fifo_rd_en), 32'd1);
      rx_frame(-1, fr, he, idl, lb);
      chk("a5_frame", 32'(fr), 32'(exp_frame(8'hA5)));
`ifndef FIFO_SER_TX_PARITY_EN
      chk("a5_frame_const", 32'(fr), 32'h34A);
`endif
      chk("a5_hold", 32'(he), 32'd0);
      chk("a5_busy_last", 32'(lb), 32'd1);
      chk("a5_busy_after", 32'(busy), 32'd0);
      chk("a5_pops", 32'(pops - p0), 32'd1);
      chk("a5_frame_cnt", 32'(frame_cnt), 32'd1);

      // Three back-to-back frames
      p0 = pops;
      push(8'h01);
      push(8'h02);
      push(8'h03);
      rx_frame(-1, fr, he, idl, lb);
      chk("b2b0_frame", 32'(fr), 32'(exp_frame(8'h01)));
      chk("b2b0_hold", 32'(he), 32'd0);
      rx_frame(-1, fr, he, idl, lb);
      chk("b2b1_frame", 32'(fr), 32'(exp_frame(8'h02)));
      chk("b2b1_gap", 32'(idl), 32'd0);
      rx_frame(-1, fr, he, idl, lb);
      chk("b2b2_frame", 32'(fr), 32'(exp_frame(8'h03)));
      chk("b2b2_gap", 32'(idl), 32'd0);
      chk("b2b_busy_last", 32'(lb), 32'd1);
      chk("b2b_busy_after", 32'(busy), 32'd0);
      chk("b2b_pops", 32'(pops - p0), 32'd3);
      chk("b2b_fifo_left", 32'(wp - rp), 32'd0);
      chk("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

      // Empty FIFO with tx_en held high
      bad_rd   = 0;
      bad_tx   = 0;
      bad_busy = 0;
      for (int i = 0; i < 100; i++) begin
         if (fifo_rd_en !== 1'b0) bad_rd++;
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         @(negedge clk);
      end
      chk("empty_rd_en", 32'(bad_rd), 32'd0);
      chk("empty_tx", 32'(bad_tx), 32'd0);
      chk("empty_busy", 32'(bad_busy), 32'd0);

      // tx_en dropped during data bit 2 of 0x3C with two bytes queued behind it
      p0 = pops;
      push(8'h3C);
      push(8'hAA);
      push(8'h55);
      rx_frame(12, fr, he, idl, lb);
      chk("drop_frame", 32'(fr), 32'(exp_frame(8'h3C)));
      chk("drop_hold", 32'(he), 32'd0);
      repeat (20) @(negedge clk);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_pops", 32'(pops - p0), 32'd1);
      chk("drop_fifo_left", 32'(wp - rp), 32'd2);
      chk("drop_frame_cnt", 32'(frame_cnt), 32'd5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;

      // Asynchronous reset in the middle of data bit 3
      tx_en = 1'b1;
      push(8'h5A);
      wait_start(idl, tmo);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(8'hC3);
      rx_frame(-1, fr, he, idl, lb);
      chk("post_rst_frame", 32'(fr), 32'(exp_frame(8'hC3)));
      chk("post_rst_hold", 32'(he), 32'd0);
      chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef FIFO_SER_TX_PARITY_EN
      push(8'h07);
      rx_frame(-1, fr, he, idl, lb);
      chk("par_frame", 32'(fr), 32'h60E);
      chk("par_hold", 32'(he), 32'd0);
      chk("par_busy_after", 32'(busy), 32'd0);
`endif

      chk("no_underflow", 32'(underflow), 32'd0);
      chk("no_double_pop", 32'(dbl), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
